// File: rtl/imem_fetch_port_pkg.sv
// Shared definitions for the instruction-memory fetch port.
//   FAULT_MISALIGN / FAULT_RANGE : bits of the 2-bit response fault code
//   NOP_WORD_DEFAULT             : word returned in place of a faulted fetch
//   resp_t                       : response record {data, addr, fault} at default widths
package imem_fetch_port_pkg;

   localparam logic [1:0]  FAULT_MISALIGN   = 2'b01;
   localparam logic [1:0]  FAULT_RANGE      = 2'b10;
   localparam logic [31:0] NOP_WORD_DEFAULT = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] data;
      logic [31:0] addr;
      logic [1:0]  fault;
   } resp_t;

endpackage

// File: rtl/imem_resp_fifo.sv
// Two-entry response FIFO with bypass and flush.
//   clk, reset_n        : clock, asynchronous active-low reset
//   flush               : drop every entry; out_valid forced low this cycle
//   in_valid, in_data   : RAM read result, valid for exactly one cycle
//   out_valid, out_ready: response handshake toward the consumer
//   out_data            : oldest entry, or in_data directly when empty
//   count               : number of buffered entries (0..2)
module imem_resp_fifo #(
   parameter int unsigned WIDTH = 66
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       count
);

   logic [WIDTH-1:0] slot_q [2];
   logic [WIDTH-1:0] slot_d [2];
   logic             rd_ptr_q, rd_ptr_d;
   logic             wr_ptr_q, wr_ptr_d;
   logic [1:0]       count_q,  count_d;
   logic             deq, pop, enq;

   always_comb begin
      slot_d   = slot_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;

      out_valid = !flush && ((count_q != 2'd0) || in_valid);
      if (count_q != 2'd0)
         out_data = slot_q[rd_ptr_q];
      else if (in_valid)
         out_data = in_data;
      else
         out_data = '0;

      deq = out_valid && out_ready;
      // A dequeue while empty consumes the bypassed word, so it is never stored.
      pop = deq && (count_q != 2'd0);
      enq = in_valid && !(deq && (count_q == 2'd0));

      if (flush) begin
         rd_ptr_d = 1'b0;
         wr_ptr_d = 1'b0;
         count_d  = 2'd0;
      end else begin
         if (enq) begin
            slot_d[wr_ptr_q] = in_data;
            wr_ptr_d         = ~wr_ptr_q;
         end
         if (pop)
            rd_ptr_d = ~rd_ptr_q;
         count_d = count_q + {1'b0, enq} - {1'b0, pop};
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         slot_q   <= '{default: '0};
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         slot_q   <= slot_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/imem_fetch_port.sv
// Instruction RAM fetch port: word-organised synchronous-read RAM behind
// valid/ready request/response channels, with a loader write port.
//   clk, reset_n                          : clock, asynchronous active-low reset
//   io_req_valid/ready/addr               : byte-addressed fetch request
//   io_resp_valid/ready/data/addr/fault   : in-order response (NOP_WORD on fault)
//   io_flush                              : drop in-flight and buffered responses
//   io_wr_en/addr/data                    : loader write, blocks fetch that cycle
module imem_fetch_port
   import imem_fetch_port_pkg::*;
#(
   parameter int unsigned             DATA_WIDTH = 32,
   parameter int unsigned             DEPTH      = 1024,
   parameter int unsigned             ADDR_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0]   NOP_WORD   = NOP_WORD_DEFAULT
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  io_req_valid,
   output logic                  io_req_ready,
   input  logic [ADDR_WIDTH-1:0] io_req_addr,
   output logic                  io_resp_valid,
   input  logic                  io_resp_ready,
   output logic [DATA_WIDTH-1:0] io_resp_data,
   output logic [ADDR_WIDTH-1:0] io_resp_addr,
   output logic [1:0]            io_resp_fault,
   input  logic                  io_flush,
   input  logic                  io_wr_en,
   input  logic [ADDR_WIDTH-1:0] io_wr_addr,
   input  logic [DATA_WIDTH-1:0] io_wr_data
);

   localparam int unsigned IDX_W  = $clog2(DEPTH);
   localparam int unsigned RESP_W = DATA_WIDTH + ADDR_WIDTH + 2;

   function automatic logic [1:0] fault_of(input logic [ADDR_WIDTH-1:0] a);
      logic [1:0] f;
      f = '0;
      if (a[1:0] != 2'b00)
         f = f | FAULT_MISALIGN;
      if ((a >> (IDX_W + 2)) != '0)
         f = f | FAULT_RANGE;
      return f;
   endfunction

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] ram_rdata_q;

   logic                  inflight_q,  inflight_d;
   logic [ADDR_WIDTH-1:0] req_addr_q,  req_addr_d;
   logic [1:0]            req_fault_q, req_fault_d;

   logic [1:0]            req_fault, wr_fault, buf_count, occupancy;
   logic [IDX_W-1:0]      req_idx, wr_idx;
   logic                  accept;
   logic [RESP_W-1:0]     fifo_in, fifo_out;

   always_comb begin
      req_fault = fault_of(io_req_addr);
      wr_fault  = fault_of(io_wr_addr);
      req_idx   = io_req_addr[IDX_W+1:2];
      wr_idx    = io_wr_addr[IDX_W+1:2];

      // The in-flight read counts toward occupancy so a stalled consumer
      // always leaves room in the buffer for the word now leaving the RAM.
      occupancy    = buf_count + {1'b0, inflight_q};
      io_req_ready = reset_n && !io_wr_en && !io_flush && (occupancy < 2'd2);
      accept       = io_req_valid && io_req_ready;

      inflight_d  = accept;
      req_addr_d  = accept ? io_req_addr : req_addr_q;
      req_fault_d = accept ? req_fault   : req_fault_q;

      fifo_in = {(req_fault_q != 2'b00) ? NOP_WORD : ram_rdata_q, req_addr_q, req_fault_q};
      {io_resp_data, io_resp_addr, io_resp_fault} = fifo_out;
   end

   // Storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (io_wr_en && (wr_fault == 2'b00))
         mem[wr_idx] <= io_wr_data;
      if (accept)
         ram_rdata_q <= mem[req_idx];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         inflight_q  <= 1'b0;
         req_addr_q  <= '0;
         req_fault_q <= '0;
      end else begin
         inflight_q  <= inflight_d;
         req_addr_q  <= req_addr_d;
         req_fault_q <= req_fault_d;
      end
   end

   imem_resp_fifo #(
      .WIDTH (RESP_W)
   ) u_resp_fifo (
      .clk       (clk),
      .reset_n   (reset_n),
      .flush     (io_flush),
      .in_valid  (inflight_q),
      .in_data   (fifo_in),
      .out_valid (io_resp_valid),
      .out_ready (io_resp_ready),
      .out_data  (fifo_out),
      .count     (buf_count)
   );

endmodule

// File: tb/tb_imem_fetch_port.sv
module tb_imem_fetch_port;
   import imem_fetch_port_pkg::*;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        io_req_valid;
   logic        io_req_ready;
   logic [31:0] io_req_addr;
   logic        io_resp_valid;
   logic        io_resp_ready;
   logic [31:0] io_resp_data;
   logic [31:0] io_resp_addr;
   logic [1:0]  io_resp_fault;
   logic        io_flush;
   logic        io_wr_en;
   logic [31:0] io_wr_addr;
   logic [31:0] io_wr_data;

   int checks   = 0;
   int failures = 0;

   // Reference model: word memory plus an ordered list of owed responses.
   // Every accepted request becomes visible one cycle later, so "owed and
   // not flushed" is exactly when a response must be presented.
   logic [31:0] mem_m [1024];
   resp_t       exp_q [$];

   always #5 clk = ~clk;

   imem_fetch_port #(
      .DATA_WIDTH (32),
      .DEPTH      (1024),
      .ADDR_WIDTH (32),
      .NOP_WORD   (32'h0000_0013)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .io_req_valid  (io_req_valid),
      .io_req_ready  (io_req_ready),
      .io_req_addr   (io_req_addr),
      .io_resp_valid (io_resp_valid),
      .io_resp_ready (io_resp_ready),
      .io_resp_data  (io_resp_data),
      .io_resp_addr  (io_resp_addr),
      .io_resp_fault (io_resp_fault),
      .io_flush      (io_flush),
      .io_wr_en      (io_wr_en),
      .io_wr_addr    (io_wr_addr),
      .io_wr_data    (io_wr_data)
   );

   function automatic resp_t model_resp(input logic [31:0] a);
      resp_t r;
      r.addr     = a;
      r.fault[0] = (a % 4) != 0;
      r.fault[1] = (a / 4) >= 1024;
      r.data     = (r.fault != 2'b00) ? 32'h0000_0013 : mem_m[(a / 4) % 1024];
      return r;
   endfunction

   // One clock cycle: drive at edge+1, check at mid-cycle, advance model at edge.
   task automatic step(input logic rv, input logic [31:0] ra, input logic rr,
                       input logic fl, input logic we, input logic [31:0] wa,
                       input logic [31:0] wd);
      logic  exp_ready, exp_valid;
      resp_t head;
      io_req_valid  = rv;
      io_req_addr   = ra;
      io_resp_ready = rr;
      io_flush      = fl;
      io_wr_en      = we;
      io_wr_addr    = wa;
      io_wr_data    = wd;
      #4;
      exp_ready = !we && !fl && (exp_q.size() < 2);
      exp_valid = !fl && (exp_q.size() > 0);
      checks++;
      if (io_req_ready !== exp_ready) begin
         failures++;
         $display("FAIL req_ready t=%0t got=%b exp=%b", $time, io_req_ready, exp_ready);
      end
      checks++;
      if (io_resp_valid !== exp_valid) begin
         failures++;
         $display("FAIL resp_valid t=%0t got=%b exp=%b", $time, io_resp_valid, exp_valid);
      end
      if (exp_valid) begin
         head = exp_q[0];
         checks++;
         if ({io_resp_data, io_resp_addr, io_resp_fault} !== head) begin
            failures++;
            $display("FAIL resp_fields t=%0t got data=%h addr=%h fault=%b exp data=%h addr=%h fault=%b",
                     $time, io_resp_data, io_resp_addr, io_resp_fault, head.data, head.addr, head.fault);
         end
      end
      @(posedge clk);
      if (fl) begin
         exp_q.delete();
      end else begin
         if (exp_valid && rr) void'(exp_q.pop_front());
         if (rv && exp_ready) exp_q.push_back(model_resp(ra));
      end
      if (we && (wa % 4 == 0) && (wa / 4 < 1024)) mem_m[wa / 4] = wd;
      #1;
   endtask

   task automatic idle(input logic rr);
      step(1'b0, 32'h0, rr, 1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      io_req_valid = 1'b1; io_req_addr = 32'h0; io_resp_ready = 1'b1;
      io_flush = 1'b0; io_wr_en = 1'b0; io_wr_addr = 32'h0; io_wr_data = 32'h0;
      #2;
      checks++;
      if (io_req_ready !== 1'b0 || io_resp_valid !== 1'b0) begin
         failures++;
         $display("FAIL reset_handshake got ready=%b valid=%b exp 0 0", io_req_ready, io_resp_valid);
      end
      checks++;
      if (io_resp_data !== 32'h0 || io_resp_addr !== 32'h0 || io_resp_fault !== 2'b00) begin
         failures++;
         $display("FAIL reset_fields got data=%h addr=%h fault=%b exp all 0",
                  io_resp_data, io_resp_addr, io_resp_fault);
      end
      @(posedge clk); @(posedge clk); #1;
      reset_n = 1'b1;
      exp_q.delete();
   endtask

   task automatic test_load_back_to_back;
      for (int i = 0; i < 16; i++)
         step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'(i * 4),
              (i < 4) ? 32'h1111_1111 * 32'(i + 1) : $urandom);
      for (int i = 0; i < 4; i++)
         step(1'b1, 32'(i * 4), 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      idle(1'b1);
      idle(1'b1);
      checks++;
      if (io_resp_valid !== 1'b0) begin
         failures++;
         $display("FAIL b2b_drained got valid=%b exp 0", io_resp_valid);
      end
   endtask

   task automatic test_backpressure;
      step(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      step(1'b1, 32'h4, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      step(1'b1, 32'h8, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      for (int i = 0; i < 5; i++) begin
         idle(1'b0);
         checks++;
         if (io_resp_valid !== 1'b1 || io_resp_data !== 32'h1111_1111 || io_resp_addr !== 32'h0) begin
            failures++;
            $display("FAIL bp_stable cyc=%0d got valid=%b data=%h addr=%h exp 1 11111111 0",
                     i, io_resp_valid, io_resp_data, io_resp_addr);
         end
      end
      idle(1'b1);
      idle(1'b1);
      idle(1'b1);
   endtask

   task automatic test_faults;
      step(1'b1, 32'h2,    1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      step(1'b1, 32'h4,    1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      step(1'b1, 32'h1000, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      step(1'b1, 32'hC,    1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      idle(1'b1);
      idle(1'b1);
   endtask

   task automatic test_flush;
      step(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      step(1'b1, 32'h4, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      idle(1'b0);
      step(1'b1, 32'hC, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
      step(1'b1, 32'h8, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      idle(1'b1);
      idle(1'b1);
      checks++;
      if (io_resp_valid !== 1'b0) begin
         failures++;
         $display("FAIL flush_no_stale got valid=%b exp 0", io_resp_valid);
      end
   endtask

   task automatic test_loader_write;
      step(1'b1, 32'h0,    1'b1, 1'b0, 1'b1, 32'h4,    32'hDEAD_BEEF);
      step(1'b1, 32'h4,    1'b1, 1'b0, 1'b0, 32'h0,    32'h0);
      step(1'b0, 32'h0,    1'b1, 1'b0, 1'b1, 32'h1004, 32'hBAD0_0001);
      step(1'b0, 32'h0,    1'b1, 1'b0, 1'b1, 32'h6,    32'hBAD0_0002);
      step(1'b1, 32'h4,    1'b1, 1'b0, 1'b0, 32'h0,    32'h0);
      step(1'b1, 32'h8,    1'b1, 1'b0, 1'b0, 32'h0,    32'h0);
      idle(1'b1);
   endtask

   task automatic test_reset_midstream;
      step(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      step(1'b1, 32'h4, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      reset_n = 1'b0;
      #1;
      checks++;
      if (io_resp_valid !== 1'b0 || io_req_ready !== 1'b0) begin
         failures++;
         $display("FAIL midreset_handshake got valid=%b ready=%b exp 0 0", io_resp_valid, io_req_ready);
      end
      checks++;
      if (io_resp_data !== 32'h0 || io_resp_fault !== 2'b00) begin
         failures++;
         $display("FAIL midreset_fields got data=%h fault=%b exp 0 0", io_resp_data, io_resp_fault);
      end
      exp_q.delete();
      @(posedge clk); #1;
      reset_n = 1'b1;
      idle(1'b1);
      idle(1'b1);
      step(1'b1, 32'h4, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      idle(1'b1);
   endtask

   task automatic test_random;
      logic        rv, rr, fl, we;
      logic [31:0] ra, wa;
      for (int i = 0; i < 400; i++) begin
         rv = ($urandom_range(0, 99) < 70);
         rr = ($urandom_range(0, 99) < 60);
         fl = ($urandom_range(0, 99) < 5);
         we = ($urandom_range(0, 99) < 6);
         ra = ($urandom_range(0, 99) < 85) ? 32'($urandom_range(0, 15) * 4) : $urandom;
         wa = ($urandom_range(0, 99) < 80) ? 32'($urandom_range(0, 15) * 4) : $urandom;
         step(rv, ra, rr, fl, we, wa, $urandom);
      end
      for (int i = 0; i < 3; i++) idle(1'b1);
   endtask

   initial begin
      test_reset();
      test_load_back_to_back();
      test_backpressure();
      test_faults();
      test_flush();
      test_loader_write();
      test_reset_midstream();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/imem_fetch_port.md
Name: imem_fetch_port

Overview:
- Parametrised successor to the single-cycle instruction memory.
- Word-organised instruction RAM with synchronous read and byte-addressed, word-aligned fetch requests.
- valid/ready request and response channels, with a 2-entry response buffer so the fetch stage can apply backpressure and redirect-flush.
- Loader write port for program load; sits between PC/fetch logic and decode.

Parameters:
- DATA_WIDTH, 32, instruction word width in bits.
- DEPTH, 1024, number of words (power of two, >= 2).
- ADDR_WIDTH, 32, byte-address width of request and loader ports.
- NOP_WORD, 32'h00000013, data returned on faulted fetch.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- io_req_valid  input  1  fetch request valid.
- io_req_ready  output  1  request accepted when valid && ready.
- io_req_addr  input  ADDR_WIDTH  byte address of instruction.
- io_resp_valid  output  1  response valid.
- io_resp_ready  input  1  consumer accepts response.
- io_resp_data  output  DATA_WIDTH  instruction word (NOP_WORD on fault).
- io_resp_addr  output  ADDR_WIDTH  echo of request address.
- io_resp_fault  output  2  bit0 misaligned, bit1 out of range.
- io_flush  input  1  discard all in-flight and buffered responses.
- io_wr_en  input  1  loader write strobe.
- io_wr_addr  input  ADDR_WIDTH  loader byte address.
- io_wr_data  input  DATA_WIDTH  loader word.

Behaviour:
- Word index = addr[log2(DEPTH)+1:2]. addr[1:0]!=0 sets fault bit0. addr >> 2 >= DEPTH (any upper bit set) sets fault bit1. A faulted request is still accepted and answered in order; its response carries NOP_WORD.
- Storage is not reset. Contents are undefined until written.
- Occupancy = buffered entries + in-flight read (0..2).
- io_req_ready = reset_n && !io_wr_en && !io_flush && occupancy < 2. Combinational, does not depend on io_req_valid.
- Read latency is 1 cycle. A request accepted at edge N has its RAM output valid in cycle N+1.
  - If the buffer is empty, the response is presented directly in cycle N+1 (bypass).
  - Otherwise it is enqueued at edge N+1 behind older entries.
- Responses are strictly in request order.
- Handshake: io_resp_valid and all io_resp_* fields stay stable until io_resp_ready. Data must not change under backpressure, so the RAM output is captured into the buffer if not consumed in cycle N+1.
- Simultaneous dequeue and accept at occupancy 2 is not allowed (ready is low). At occupancy 1 with a dequeue, a new accept is allowed; throughput is 1 fetch/cycle when io_resp_ready stays high.
- Flush:
  - At the edge where io_flush=1, the buffer and in-flight read are dropped and occupancy becomes 0.
  - io_resp_valid is forced low combinationally in the flush cycle.
  - No request is accepted in that cycle.
  - A request on the following cycle proceeds normally.
- Loader write: at an edge with io_wr_en=1, mem[word index] <= io_wr_data.
  - Out-of-range or misaligned writes are ignored.
  - Reads are blocked in that cycle, so there is no read/write collision.
  - A read accepted the next cycle returns the new data.
- Reset (asynchronous assertion, synchronous release): pointers, occupancy and in-flight flag clear. io_resp_valid=0, io_req_ready=0 while reset_n=0. io_resp_data/addr/fault reset to 0. Reset mid-transfer discards everything.

Decomposition:
- Shared package holds:
  - Fault encoding constants FAULT_MISALIGN=2'b01, FAULT_RANGE=2'b10.
  - NOP_WORD default.
  - The response struct {data, addr, fault}.
- One sub-module, imem_resp_fifo: a 2-entry FIFO with bypass and flush, parametrised on struct width.
- RAM array and fault decode stay in the top level.

Test Plan:
- Load words 0..3 with 0x11111111..0x44444444 via loader, then back-to-back requests to 0x0,0x4,0x8,0xC with resp_ready=1 -> responses 1 cycle after each accept, in order, 1/cycle, fault=0.
- Requests to 0x0,0x4 with resp_ready=0 -> ready drops after 2 accepts. Data 0x11111111 is held stable for 5 cycles. Raising resp_ready drains both in order and ready returns high.
- Request 0x2 -> data 0x00000013, fault=01. Request 0x1000 (DEPTH=1024) -> data 0x00000013, fault=10. Both are ordered correctly among normal fetches.
- Two responses buffered, pulse flush -> resp_valid low in the flush cycle and after. Request 0x8 next cycle -> 0x33333333 only.
- Write 0xDEADBEEF to 0x4 while req_valid=1 -> req_ready=0 in that cycle. Request 0x4 next cycle -> 0xDEADBEEF.
- Assert reset_n=0 mid-stream with 2 outstanding -> resp_valid=0 immediately. After release, no stale response. Memory contents are preserved.
